// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor built around one full-adder cell.
// Operands are captured on start and processed LSB first, one bit per clock.
// The result, carry-out and signed overflow are registered and held until the
// next completion; done pulses for one cycle when they update.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  // Counter needs at least one bit even when WIDTH is 1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic             sum_bit_s;
  logic             carry_next_s;
  logic             last_step_s;
  logic [WIDTH-1:0] res_shift_s;

  // Carry of a full adder: majority of its three inputs.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Full-adder cell on the current LSBs plus the result shifted in from the MSB end.
  always_comb begin
    sum_bit_s              = ra_q[0] ^ rb_q[0] ^ carry_q;
    carry_next_s           = maj3(ra_q[0], rb_q[0], carry_q);
    last_step_s            = (cnt_q == CW'(WIDTH - 1));
    res_shift_s            = res_q >> 1;
    res_shift_s[WIDTH-1]   = sum_bit_s;
  end

  // Next-state and output logic: accept in IDLE, shift one bit per RUN edge, publish on the last step.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1; the forced carry supplies the +1.
          ra_d    = a;
          rb_d    = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          res_d   = {WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        ra_d    = ra_q >> 1;
        rb_d    = rb_q >> 1;
        carry_d = carry_next_s;
        res_d   = res_shift_s;
        cnt_d   = cnt_q + CW'(1);
        if (last_step_s) begin
          // carry_q is the carry into the MSB here, so overflow is its xor with carry-out.
          s_d     = res_shift_s;
          co_d    = carry_next_s;
          ovf_d   = carry_q ^ carry_next_s;
          done_d  = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that overrides start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= {WIDTH{1'b0}};
      rb_q    <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      s_q     <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and random checks of serial_add_sub at WIDTH = 8, 1 and 16.
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       st8, sub8, cin8, busy8, done8, co8, ovf8;
  logic [7:0] a8, b8, s8;
  logic       st1, sub1, cin1, busy1, done1, co1, ovf1;
  logic [0:0] a1, b1, s1;
  logic        st16, sub16, cin16, busy16, done16, co16, ovf16;
  logic [15:0] a16, b16, s16;

  int n_tests = 0;
  int n_fail  = 0;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .co(co8), .ovf(ovf8));

  serial_add_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .s(s1), .co(co1), .ovf(ovf1));

  serial_add_sub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(st16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .s(s16), .co(co16), .ovf(ovf16));

  typedef struct packed {
    logic       sb;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec8_t;

  // Launch one WIDTH=8 operation; scramble inputs during RUN; return results, latency and busy count.
  task automatic op8(input logic sb, input logic [7:0] aa, input logic [7:0] bb, input logic ci,
                     output logic [7:0] rs, output logic rco, output logic rov,
                     output int lat, output int bcnt);
    @(negedge clk);
    sub8 = sb; a8 = aa; b8 = bb; cin8 = ci; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0; a8 = ~aa; b8 = ~bb; sub8 = ~sb; cin8 = ~ci;
    lat = 0; bcnt = 0;
    while (done8 !== 1'b1 && lat < 64) begin
      if (busy8 === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    rs = s8; rco = co8; rov = ovf8;
  endtask

  task automatic op1(input logic sb, input logic aa, input logic bb, input logic ci,
                     output logic rs, output logic rco, output logic rov, output int lat);
    @(negedge clk);
    sub1 = sb; a1 = aa; b1 = bb; cin1 = ci; st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0; a1 = ~aa; b1 = ~bb;
    lat = 0;
    while (done1 !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    rs = s1[0]; rco = co1; rov = ovf1;
  endtask

  task automatic op16(input logic sb, input logic [15:0] aa, input logic [15:0] bb, input logic ci,
                      output logic [15:0] rs, output logic rco, output logic rov, output int lat);
    @(negedge clk);
    sub16 = sb; a16 = aa; b16 = bb; cin16 = ci; st16 = 1'b1;
    @(negedge clk);
    st16 = 1'b0; a16 = ~aa; b16 = ~bb;
    lat = 0;
    while (done16 !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    rs = s16; rco = co16; rov = ovf16;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    st8 = 1'b1; sub8 = 1'b0; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
    repeat (2) @(negedge clk);
    st8 = 1'b0;
    n_tests++;
    if ({busy8, done8, co8, ovf8} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done/co/ovf=%b required 0000", {busy8, done8, co8, ovf8});
    end
    n_tests++;
    if (s8 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_s: s=%h required 00", s8);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_sub();
    vec8_t      v[9];
    logic [7:0] rs;
    logic       rco, rov;
    int         lat, bcnt;
    v = '{
      '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0},
      '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
      '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
      '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0},
      '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
      '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0},
      '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1},
      '{1'b1, 8'h07, 8'h07, 1'b0, 8'h00, 1'b1, 1'b0},
      '{1'b1, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0}
    };
    for (int i = 0; i < 9; i++) begin
      op8(v[i].sb, v[i].a, v[i].b, v[i].ci, rs, rco, rov, lat, bcnt);
      n_tests++;
      if ({rs, rco, rov} !== {v[i].s, v[i].co, v[i].ov}) begin
        n_fail++;
        $display("FAIL op8_%0d: s/co/ovf=%h/%b/%b required %h/%b/%b",
                 i, rs, rco, rov, v[i].s, v[i].co, v[i].ov);
      end
      n_tests++;
      if (lat !== 8 || bcnt !== 8) begin
        n_fail++;
        $display("FAIL timing8_%0d: latency=%0d busy_cycles=%0d required 8/8", i, lat, bcnt);
      end
      @(negedge clk);
      n_tests++;
      if (done8 !== 1'b0 || s8 !== v[i].s) begin
        n_fail++;
        $display("FAIL done_pulse_%0d: done=%b s=%h required 0/%h", i, done8, s8, v[i].s);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int held_bad;
    @(negedge clk);
    sub8 = 1'b0; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 64) begin
      if (cyc == 2 || cyc == 4) begin
        st8 = 1'b1; sub8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        st8 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc !== 8 || {s8, co8, ovf8} !== {8'h30, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ignore_start: latency=%0d s/co/ovf=%h/%b/%b required 8 30/0/0", cyc, s8, co8, ovf8);
    end
    // Start in the done cycle must be accepted.
    sub8 = 1'b1; a8 = 8'h55; b8 = 8'h2A; cin8 = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    cyc = 0; held_bad = 0;
    while (done8 !== 1'b1 && cyc < 64) begin
      if (busy8 !== 1'b1 || s8 !== 8'h30) held_bad++;
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (held_bad !== 0) begin
      n_fail++;
      $display("FAIL held_result: %0d cycles with busy low or s changed, required 0", held_bad);
    end
    n_tests++;
    if (cyc !== 8 || {s8, co8, ovf8} !== {8'h2B, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL done_cycle_start: latency=%0d s/co/ovf=%h/%b/%b required 8 2b/1/0", cyc, s8, co8, ovf8);
    end
  endtask

  task automatic test_reset_mid();
    int         seen_done;
    logic [7:0] rs;
    logic       rco, rov;
    int         lat, bcnt;
    @(negedge clk);
    sub8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({busy8, done8, s8, co8, ovf8} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid: busy/done/s/co/ovf=%b/%b/%h/%b/%b required all 0",
               busy8, done8, s8, co8, ovf8);
    end
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) seen_done++;
    end
    n_tests++;
    if (seen_done !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: %0d cycles of done/busy after abort, required 0", seen_done);
    end
    op8(1'b0, 8'h12, 8'h34, 1'b0, rs, rco, rov, lat, bcnt);
    n_tests++;
    if (lat !== 8 || {rs, rco, rov} !== {8'h46, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL after_reset: latency=%0d s/co/ovf=%h/%b/%b required 8 46/0/0", lat, rs, rco, rov);
    end
  endtask

  task automatic test_width1();
    logic       rs, rco, rov, sbb;
    logic [1:0] sum;
    int         lat;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] k;
      k = 4'(i);
      op1(k[3], k[2], k[1], k[0], rs, rco, rov, lat);
      sbb = k[3] ? ~k[1] : k[1];
      sum = 2'(k[2]) + 2'(sbb) + 2'(k[3] ? 1'b1 : k[0]);
      n_tests++;
      if ({rs, rco, rov, lat} !== {sum[0], sum[1], (k[2] == sbb) && (sum[0] != k[2]), 32'd1}) begin
        n_fail++;
        $display("FAIL w1 sub=%b a=%b b=%b cin=%b: s/co/ovf=%b/%b/%b lat=%0d required %b/%b/%b lat=1",
                 k[3], k[2], k[1], k[0], rs, rco, rov, lat,
                 sum[0], sum[1], (k[2] == sbb) && (sum[0] != k[2]));
      end
    end
  endtask

  task automatic test_width16();
    logic [15:0] aa, bb, bx, rs;
    logic [16:0] sum;
    logic        sb, ci, rco, rov, eov;
    int          lat;
    for (int i = 0; i < 1000; i++) begin
      aa = 16'($urandom);
      bb = 16'($urandom);
      sb = 1'(i & 1);
      ci = 1'($urandom_range(0, 1));
      if (i == 0) begin aa = 16'h7FFF; bb = 16'h0001; sb = 1'b0; ci = 1'b0; end
      if (i == 1) begin aa = 16'h8000; bb = 16'h0001; sb = 1'b1; ci = 1'b0; end
      op16(sb, aa, bb, ci, rs, rco, rov, lat);
      bx  = sb ? ~bb : bb;
      sum = 17'(aa) + 17'(bx) + 17'(sb ? 1'b1 : ci);
      eov = (aa[15] == bx[15]) && (sum[15] != aa[15]);
      n_tests++;
      if ({rs, rco, rov} !== {sum[15:0], sum[16], eov} || lat !== 16) begin
        n_fail++;
        $display("FAIL w16_%0d sub=%b a=%h b=%h cin=%b: s/co/ovf=%h/%b/%b lat=%0d required %h/%b/%b lat=16",
                 i, sb, aa, bb, ci, rs, rco, rov, lat, sum[15:0], sum[16], eov);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    st8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    st1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    st16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    test_width16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
